// File: rtl/extend_target_unit.sv
// -----------------------------------------------------------------------------
// extend_target_unit
//
// Immediate extension / jump-and-branch target unit with a valid/ready
// handshake on both sides. A request is captured in IDLE, its result is
// computed and registered in CALC, and presented in HOLD until the consumer
// takes it. One result per three cycles when the consumer never stalls.
//
// Parameters
//   DATA_W  result / PC width
//   IMM_W   immediate field width (IMM_W + SHAMT must not exceed DATA_W)
//   SHAMT   word-alignment shift applied to JUMP and BRANCH immediates
//
// Ports
//   clk        clock, all state updates on its rising edge
//   reset      synchronous active-high reset
//   in_valid   request present
//   in_ready   unit accepts a request this cycle (IDLE only, state-driven)
//   mode       00 ZERO, 01 SIGN, 10 JUMP, 11 BRANCH
//   imm        immediate field
//   pc         current PC (JUMP / BRANCH)
//   out_valid  result valid (registered)
//   out_ready  consumer accepts the result
//   result     extended value or target address (registered)
//   wrap       BRANCH addition carried or borrowed past DATA_W (registered)
// -----------------------------------------------------------------------------
module extend_target_unit #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 26,
  parameter int SHAMT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              wrap
);

  localparam int LOW_W = IMM_W + SHAMT;

  localparam logic [1:0] MODE_ZERO   = 2'b00;
  localparam logic [1:0] MODE_SIGN   = 2'b01;
  localparam logic [1:0] MODE_JUMP   = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_reg;
  logic [1:0]          mode_reg;
  logic [IMM_W-1:0]    imm_reg;
  logic [DATA_W-1:0]   pc_reg;
  logic [DATA_W-1:0]   result_reg;
  logic                wrap_reg;
  logic                out_valid_reg;

  // Combinational datapath, fed only from the captured registers so that no
  // input reaches result/wrap without passing through a flop first.
  logic [DATA_W-1:0]   imm_zext;
  logic [DATA_W-1:0]   imm_sext;
  logic [DATA_W-1:0]   branch_offset;
  logic [DATA_W-1:0]   jump_target;
  logic [DATA_W:0]     branch_sum;
  logic                offset_neg;
  logic [DATA_W-1:0]   result_next;
  logic                wrap_next;

  assign imm_zext = DATA_W'(imm_reg);
  assign imm_sext = DATA_W'($signed(imm_reg));

  // Shift at full DATA_W width; anything pushed past the top is dropped.
  assign branch_offset = imm_sext << SHAMT;
  assign offset_neg    = imm_reg[IMM_W-1];

  // One extra bit catches the carry out of the unsigned addition.
  assign branch_sum = {1'b0, pc_reg} + {1'b0, branch_offset};

  // Jump target assembled bit by bit: alignment zeros at the bottom, the
  // immediate above them, and whatever PC bits remain on top. When
  // IMM_W + SHAMT == DATA_W the PC branch of this generate never elaborates.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_jump_bit
      if (gi < SHAMT) begin : g_align
        assign jump_target[gi] = 1'b0;
      end else if (gi < LOW_W) begin : g_imm
        assign jump_target[gi] = imm_reg[gi-SHAMT];
      end else begin : g_pc
        assign jump_target[gi] = pc_reg[gi];
      end
    end
  endgenerate

  always_comb begin
    result_next = '0;
    wrap_next   = 1'b0;
    case (mode_reg)
      MODE_ZERO:   result_next = imm_zext;
      MODE_SIGN:   result_next = imm_sext;
      MODE_JUMP:   result_next = jump_target;
      MODE_BRANCH: begin
        result_next = branch_sum[DATA_W-1:0];
        // Adding a negative offset in two's complement produces a carry
        // exactly when the true sum stays non-negative, so a missing carry
        // means the target went below zero.
        wrap_next   = offset_neg ? ~branch_sum[DATA_W] : branch_sum[DATA_W];
      end
      default: begin
        result_next = '0;
        wrap_next   = 1'b0;
      end
    endcase
  end

  // Control FSM with registered outputs. result/wrap only change in CALC,
  // so they stay stable through HOLD and keep their value after the
  // handshake until the next request is computed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      mode_reg      <= '0;
      imm_reg       <= '0;
      pc_reg        <= '0;
      result_reg    <= '0;
      wrap_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            mode_reg  <= mode;
            imm_reg   <= imm;
            pc_reg    <= pc;
            state_reg <= CALC;
          end
        end
        CALC: begin
          result_reg    <= result_next;
          wrap_reg      <= wrap_next;
          out_valid_reg <= 1'b1;
          state_reg     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign wrap      = wrap_reg;

endmodule

// File: tb/tb_extend_target_unit.sv
// -----------------------------------------------------------------------------
// tb_extend_target_unit
//
// Self-checking bench for extend_target_unit (DATA_W=32, IMM_W=26, SHAMT=2).
// Expected values come from an arithmetic reference model working on signed
// 64-bit integers. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_extend_target_unit;

  localparam int DATA_W = 32;
  localparam int IMM_W  = 26;
  localparam int SHAMT  = 2;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        mode;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              wrap;

  int n_checks;
  int n_fail;

  extend_target_unit #(
    .DATA_W(DATA_W),
    .IMM_W (IMM_W),
    .SHAMT (SHAMT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .imm      (imm),
    .pc       (pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the mathematical values.
  function automatic void model(input logic [1:0] m, input logic [IMM_W-1:0] im,
                                input logic [DATA_W-1:0] p,
                                output logic [DATA_W-1:0] r, output logic w);
    longint imm_val;
    longint sval;
    longint sum;
    longint pc_val;
    imm_val = longint'(im);
    sval    = (im[IMM_W-1]) ? imm_val - (64'sd1 <<< IMM_W) : imm_val;
    pc_val  = longint'(p);
    w = 1'b0;
    case (m)
      2'd0: begin
        sum = imm_val;
      end
      2'd1: begin
        sum = sval;
      end
      2'd2: begin
        sum = (pc_val / (64'sd1 <<< (IMM_W + SHAMT))) * (64'sd1 <<< (IMM_W + SHAMT))
              + imm_val * (64'sd1 <<< SHAMT);
      end
      default: begin
        sum = pc_val + sval * (64'sd1 <<< SHAMT);
        w = (sum < 0) || (sum > 64'sd4294967295);
      end
    endcase
    r = sum[DATA_W-1:0];
  endfunction

  // Drives one request from IDLE (called at a falling edge with the DUT in
  // IDLE), checks latency, result, stability under stall, and the return to
  // IDLE. Returns at a falling edge with the DUT back in IDLE.
  task automatic run_txn(input logic [1:0] m, input logic [IMM_W-1:0] im,
                         input logic [DATA_W-1:0] p, input int stall,
                         input string tag);
    logic [DATA_W-1:0] exp_r;
    logic              exp_w;
    model(m, im, p, exp_r, exp_w);

    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle_in_ready: got %b want 1", tag, in_ready);
    end
    in_valid  = 1'b1;
    mode      = m;
    imm       = im;
    pc        = p;
    out_ready = (stall == 0);

    @(negedge clk);  // accepted, now CALC
    in_valid = 1'b0;
    // Inputs outside IDLE must be ignored.
    mode = ~m;
    imm  = ~im;
    pc   = '0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s calc_flags: got out_valid=%b in_ready=%b want 0/0", tag, out_valid, in_ready);
    end

    @(negedge clk);  // HOLD
    n_checks++;
    if (out_valid !== 1'b1 || result !== exp_r || wrap !== exp_w) begin
      n_fail++;
      $display("FAIL %s hold_result: got v=%b r=%h w=%b want v=1 r=%h w=%b",
               tag, out_valid, result, wrap, exp_r, exp_w);
    end

    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || result !== exp_r || wrap !== exp_w || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s stall%0d: got v=%b r=%h w=%b rdy=%b want v=1 r=%h w=%b rdy=0",
                 tag, i, out_valid, result, wrap, in_ready, exp_r, exp_w);
      end
    end
    out_ready = 1'b1;

    @(negedge clk);  // back to IDLE, result retained
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== exp_r || wrap !== exp_w) begin
      n_fail++;
      $display("FAIL %s after_handshake: got v=%b rdy=%b r=%h w=%b want v=0 rdy=1 r=%h w=%b",
               tag, out_valid, in_ready, result, wrap, exp_r, exp_w);
    end
    $display("txn %s mode=%0d imm=%h pc=%h stall=%0d result=%h wrap=%b",
             tag, m, im, p, stall, result, wrap);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;  // must not be accepted while reset is high
    mode      = 2'd1;
    imm       = 26'h2AAAAAA;
    pc        = 32'h12345678;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || result !== '0 || wrap !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b r=%h w=%b rdy=%b want 0/0/0/1", out_valid, result, wrap, in_ready);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b v=%b want 1/0", in_ready, out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_no_accept: got v=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    $display("txn reset result=%h wrap=%b", result, wrap);
  endtask

  task automatic test_zero();
    run_txn(2'd0, 26'h3FFFFFF, 32'hDEADBEEF, 0, "zero_max");
    run_txn(2'd0, 26'h0000001, 32'h0,        0, "zero_one");
  endtask

  task automatic test_sign();
    run_txn(2'd1, 26'h2000000, 32'h0, 0, "sign_neg");
    run_txn(2'd1, 26'h1FFFFFF, 32'h0, 0, "sign_pos");
  endtask

  task automatic test_jump();
    run_txn(2'd2, 26'h0000010, 32'hA0000000, 0, "jump_basic");
    run_txn(2'd2, 26'h3FFFFFF, 32'h5FFFFFFF, 0, "jump_full");
  endtask

  task automatic test_branch();
    run_txn(2'd3, 26'h0000001, 32'hFFFFFFFC, 0, "branch_carry");
    run_txn(2'd3, 26'h3FFFFFF, 32'h00000000, 0, "branch_borrow");
    run_txn(2'd3, 26'h0000002, 32'h00000100, 0, "branch_plain");
    run_txn(2'd3, 26'h3FFFFFF, 32'h00000004, 0, "branch_neg_nowrap");
  endtask

  task automatic test_backpressure();
    run_txn(2'd3, 26'h0000001, 32'hFFFFFFFC, 3, "backpressure");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_txn(2'(i), IMM_W'($urandom), $urandom, 0, "b2b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      run_txn(2'($urandom_range(0, 3)), IMM_W'($urandom), $urandom,
              int'($urandom_range(0, 2)), "rand");
  endtask

  task automatic test_reset_abort();
    in_valid  = 1'b1;
    mode      = 2'd0;
    imm       = 26'h0000055;
    pc        = 32'h0;
    out_ready = 1'b1;
    @(negedge clk);  // CALC
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || result !== '0 || wrap !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_state: got v=%b r=%h w=%b rdy=%b want 0/0/0/1", out_valid, result, wrap, in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_no_result: got v=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    $display("txn reset_abort result=%h", result);
    run_txn(2'd1, 26'h2000000, 32'h0, 0, "after_abort");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    @(negedge clk);
    test_reset();
    test_zero();
    test_sign();
    test_jump();
    test_branch();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
